// File: rtl/ppu_bg_pkg.sv
// ppu_bg_pkg: shared constants, state encoding and address helpers for the
// background frame sequencer and its tile counter.
package ppu_bg_pkg;

    localparam logic [15:0] NT_BASE      = 16'h2000;
    localparam logic [15:0] NT_STRIDE    = 16'h0400;
    localparam int          TILE_COLS    = 32;
    localparam int          TILE_ROWS    = 30;
    localparam int          TILE_PX      = 8;
    localparam int          TILE_PX_LOG2 = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } bg_state_e;

    // Base address of nametable nt (0..3).
    function automatic logic [15:0] nt_base_addr(input logic [1:0] nt);
        return NT_BASE + (16'(nt) * NT_STRIDE);
    endfunction

    // Pixel origin of a tile index: index * TILE_PX.
    function automatic logic [7:0] tile_origin(input logic [4:0] idx);
        return 8'(idx) << TILE_PX_LOG2;
    endfunction

endpackage

// File: rtl/bg_tile_counter.sv
// bg_tile_counter: raster-order screen row/column counter over the tile grid.
// Exposes next-state values so the parent can register command outputs on
// the same edge the counter moves, plus a flag for the final tile.
module bg_tile_counter
    import ppu_bg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       advance_i,
    output logic [4:0] next_row_o,
    output logic [4:0] next_col_o,
    output logic       last_o
);

    localparam logic [4:0] LAST_COL = 5'(TILE_COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(TILE_ROWS - 1);

    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;

    // Next position: clear wins, otherwise step along the row and wrap.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign next_row_o = row_d;
    assign next_col_o = col_d;
    assign last_o     = (row_q == LAST_ROW) && (col_q == LAST_COL);

endmodule

// File: rtl/background_frame_sequencer.sv
// background_frame_sequencer: walks the 32x30 tile grid once per frame and
// issues one command per tile to the tile FSM.
// Optional feature macro: BG_COARSE_SCROLL_EN (coarse scroll remap of the
// tile index with nametable toggling on wrap). Video origins are never scrolled.
//
// Handshake with the tile FSM: tile_start is a 1-cycle pulse during which the
// address/origin outputs are valid; they stay stable until the next pulse.
// The tile FSM answers with a 1-cycle tile_done, which is only honoured in
// WAIT (i.e. at least one cycle after tile_start); any other tile_done is dropped.
module background_frame_sequencer
    import ppu_bg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [1:0]  nametable_sel,
    input  logic [7:0]  scroll_x,
    input  logic [7:0]  scroll_y,
    input  logic        tile_done,
    output logic        tile_start,
    output logic [15:0] nametable_base_addr,
    output logic [15:0] nametable_start_addr,
    output logic [7:0]  video_mem_row_start,
    output logic [7:0]  video_mem_col_start,
    output logic        busy,
    output logic        frame_done,
    output bg_state_e   dbg_state
);

    bg_state_e   state_q, state_d;
    logic        accept;
    logic        cnt_adv;
    logic        load_cmd;
    logic        last_tile;
    logic [4:0]  next_row, next_col;
    logic [1:0]  sel_q, sel_d;
    logic [4:0]  tile_row, tile_col;
    logic [1:0]  nt_eff;
    logic [15:0] cmd_base, cmd_addr;
    logic [15:0] base_q, addr_q;
    logic [7:0]  vrow_q, vcol_q;

`ifdef BG_COARSE_SCROLL_EN
    logic [4:0]  sx_q, sx_d, sy_q, sy_d;
    logic [4:0]  sy_eff;
    logic [5:0]  col_sum, row_sum;
    logic        unused_fine;
    // Fine scroll bits are applied downstream.
    assign unused_fine = ^{scroll_x[2:0], scroll_y[2:0]};
`else
    logic        unused_scroll;
    assign unused_scroll = ^{scroll_x, scroll_y};
`endif

    bg_tile_counter u_counter (
        .clk        (clk),
        .rst_n      (rst),
        .clear_i    (accept),
        .advance_i  (cnt_adv),
        .next_row_o (next_row),
        .next_col_o (next_col),
        .last_o     (last_tile)
    );

    // Next-state logic: one tile command per ISSUE, wait for done, step.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cnt_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE:   state_d = ST_WAIT;
            ST_WAIT:    if (tile_done) state_d = ST_ADVANCE;
            ST_ADVANCE: begin
                cnt_adv = 1'b1;
                state_d = last_tile ? ST_DONE : ST_ISSUE;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign load_cmd = (state_d == ST_ISSUE);
    assign sel_d    = accept ? nametable_sel : sel_q;
`ifdef BG_COARSE_SCROLL_EN
    assign sx_d     = accept ? scroll_x[7:3] : sx_q;
    assign sy_d     = accept ? scroll_y[7:3] : sy_q;
`endif

    // Map the next screen position to the nametable tile actually fetched.
    always_comb begin
        tile_row = next_row;
        tile_col = next_col;
        nt_eff   = sel_d;
`ifdef BG_COARSE_SCROLL_EN
        sy_eff   = (sy_d >= 5'(TILE_ROWS)) ? 5'(TILE_ROWS - 1) : sy_d;
        col_sum  = {1'b0, next_col} + {1'b0, sx_d};
        row_sum  = {1'b0, next_row} + {1'b0, sy_eff};
        tile_col = col_sum[4:0];
        if (col_sum[5]) begin
            nt_eff[0] = ~nt_eff[0];
        end
        if (row_sum >= 6'(TILE_ROWS)) begin
            tile_row  = 5'(row_sum - 6'(TILE_ROWS));
            nt_eff[1] = ~nt_eff[1];
        end else begin
            tile_row  = row_sum[4:0];
        end
`endif
        cmd_base = nt_base_addr(nt_eff);
        cmd_addr = cmd_base + {6'b0, tile_row, 5'b0} + {11'b0, tile_col};
    end

    // State, latched frame parameters and the registered tile command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
`ifdef BG_COARSE_SCROLL_EN
            sx_q    <= '0;
            sy_q    <= '0;
`endif
            base_q  <= '0;
            addr_q  <= '0;
            vrow_q  <= '0;
            vcol_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef BG_COARSE_SCROLL_EN
            sx_q    <= sx_d;
            sy_q    <= sy_d;
`endif
            if (load_cmd) begin
                base_q <= cmd_base;
                addr_q <= cmd_addr;
                vrow_q <= tile_origin(next_row);
                vcol_q <= tile_origin(next_col);
            end
        end
    end

    assign tile_start           = (state_q == ST_ISSUE);
    assign frame_done           = (state_q == ST_DONE);
    assign busy                 = (state_q != ST_IDLE);
    assign dbg_state            = state_q;
    assign nametable_base_addr  = base_q;
    assign nametable_start_addr = addr_q;
    assign video_mem_row_start  = vrow_q;
    assign video_mem_col_start  = vcol_q;

endmodule
